// File: rtl/io_rle_stream_loader_if.sv
// Token stream in, RAM write port out, for the RLE stream loader.
// The loader uses the slave modport: it sinks tokens and drives the RAM port.
interface io_rle_stream_loader_if #(
   parameter int SECTION_W = 16,
   parameter int MEM_W     = 16,
   parameter int ADDR_W    = 16
);

   logic                 in_valid;
   logic [SECTION_W-1:0] in_data;
   logic                 in_ready;
   logic                 ram_enable;
   logic                 ram_write;
   logic [ADDR_W-1:0]    ram_address;
   logic [MEM_W-1:0]     ram_wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  ram_enable,
      input  ram_write,
      input  ram_address,
      input  ram_wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output ram_enable,
      output ram_write,
      output ram_address,
      output ram_wdata
   );

endinterface

// File: rtl/io_rle_stream_loader.sv
// Streaming RLE loader: accepts run-length tokens, expands them MSB-first into
// MEM_W-bit words and writes them to RAM from a mode-selected base address.
// Completion is reported with a one-cycle done pulse and a cnn_enable level.
// ROW_W must be a multiple of MEM_W.
module io_rle_stream_loader #(
   parameter int                SECTION_W = 16,
   parameter int                ROW_W     = 512,
   parameter int                MEM_W     = 16,
   parameter int                ADDR_W    = 16,
   parameter int                ROWS_W    = 10,
   parameter logic [ADDR_W-1:0] IMG_BASE  = '0,
   parameter logic [ADDR_W-1:0] FILT_BASE = ADDR_W'(32'h8000)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 cnn_img,
   input  logic [ROWS_W-1:0]    num_rows,
   input  logic                 interrupt,
   io_rle_stream_loader_if.slave bus,
   output logic                 done,
   output logic                 cnn_enable,
   output logic                 error
);

   // Run length field width, fill counter width and a common width for the
   // min() that decides how many run bits fit into the current word.
   localparam int LEN_W  = SECTION_W - 1;
   localparam int FILL_W = $clog2(MEM_W + 1);
   localparam int CNT_W  = (LEN_W > FILL_W) ? LEN_W : FILL_W;
   localparam int WPR    = ROW_W / MEM_W;
   localparam int WIR_W  = (WPR > 1) ? $clog2(WPR) : 1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXPAND,
      DRAIN
   } state_t;

   state_t state;
   state_t state_next;

   logic [ROWS_W-1:0] rows_target;
   logic [ROWS_W-1:0] rows_done;
   logic [WIR_W-1:0]  word_in_row;
   logic [ADDR_W-1:0] address;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_sum;
   logic [MEM_W-1:0]  word;
   logic [MEM_W-1:0]  word_next;
   logic              run_value;
   logic [LEN_W-1:0]  run_rem;
   logic [LEN_W-1:0]  run_left;
   logic [CNT_W-1:0]  run_ext;
   logic [CNT_W-1:0]  space;
   logic [CNT_W-1:0]  take;
   logic              word_full;
   logic              row_end;
   logic              last_word;

   logic [LEN_W-1:0]  token_len;
   logic              token_value;
   logic              token_zero;

   logic              load_go;
   logic              fetch_go;
   logic              advance;
   logic              write_now;
   logic              drain_go;

   logic              ram_enable_q;
   logic [ADDR_W-1:0] ram_address_q;
   logic [MEM_W-1:0]  ram_wdata_q;

   assign token_len   = bus.in_data[LEN_W-1:0];
   assign token_value = bus.in_data[SECTION_W-1];
   assign token_zero  = (token_len == '0);

   // Interrupt outranks every other action, so each qualified event is gated by it.
   assign load_go   = (state == IDLE) && load && !interrupt;
   assign fetch_go  = (state == FETCH) && !interrupt && bus.in_valid && !token_zero;
   assign advance   = (state == EXPAND) && !interrupt;
   assign write_now = advance && word_full;
   assign drain_go  = (state == DRAIN) && !interrupt;

   assign bus.ram_enable  = ram_enable_q;
   assign bus.ram_write   = ram_enable_q;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_wdata   = ram_wdata_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; an interrupt in any busy state drops straight back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_go) begin
               state_next = (num_rows == '0) ? DRAIN : FETCH;
            end
         end
         FETCH: begin
            if (bus.in_valid && !token_zero) begin
               state_next = EXPAND;
            end
         end
         EXPAND: begin
            if (last_word) begin
               state_next = DRAIN;
            end else if (run_left == '0) begin
               state_next = FETCH;
            end
         end
         DRAIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (interrupt && (state != IDLE)) begin
         state_next = IDLE;
      end
   end

   // Token acceptance is purely a function of state: FETCH consumes, DRAIN discards.
   always_comb begin
      bus.in_ready = (state == FETCH) || (state == DRAIN);
   end

   // One expansion step: place min(run_remaining, free bits) copies of the run
   // value after the bits already packed, first bit at the word's MSB.
   always_comb begin
      run_ext   = CNT_W'(run_rem);
      space     = CNT_W'(MEM_W) - CNT_W'(fill);
      take      = (run_ext < space) ? run_ext : space;
      fill_sum  = fill + FILL_W'(take);
      run_left  = run_rem - LEN_W'(take);
      word_next = word;
      for (int i = 0; i < MEM_W; i++) begin
         if (run_value && (i >= int'(fill)) && (i < int'(fill_sum))) begin
            word_next[MEM_W-1-i] = 1'b1;
         end
      end
      word_full = (fill_sum == FILL_W'(MEM_W));
      row_end   = (word_in_row == WIR_W'(WPR - 1));
      last_word = word_full && row_end && (rows_done == (rows_target - ROWS_W'(1)));
   end

   // Row target captured at load so num_rows may change while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rows_target <= '0;
      end else if (load_go) begin
         rows_target <= num_rows;
      end
   end

   // Current run: value and remaining length, consumed as the words fill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_value <= 1'b0;
         run_rem   <= '0;
      end else if (load_go) begin
         run_value <= 1'b0;
         run_rem   <= '0;
      end else if (fetch_go) begin
         run_value <= token_value;
         run_rem   <= token_len;
      end else if (advance) begin
         run_rem <= run_left;
      end
   end

   // Packing register; it empties whenever a full word is handed to the RAM port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill <= '0;
         word <= '0;
      end else if (load_go) begin
         fill <= '0;
         word <= '0;
      end else if (advance) begin
         if (word_full) begin
            fill <= '0;
            word <= '0;
         end else begin
            fill <= fill_sum;
            word <= word_next;
         end
      end
   end

   // Write address: base chosen by mode at load, then one step per word, wrapping freely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address <= '0;
      end else if (load_go) begin
         address <= cnn_img ? IMG_BASE : FILT_BASE;
      end else if (write_now) begin
         address <= address + ADDR_W'(1);
      end
   end

   // Word-within-row and completed-row counters, advanced on each written word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_in_row <= '0;
         rows_done   <= '0;
      end else if (load_go) begin
         word_in_row <= '0;
         rows_done   <= '0;
      end else if (write_now) begin
         if (row_end) begin
            word_in_row <= '0;
            rows_done   <= rows_done + ROWS_W'(1);
         end else begin
            word_in_row <= word_in_row + WIR_W'(1);
         end
      end
   end

   // Registered RAM port: strobe for exactly one cycle per completed word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_enable_q  <= 1'b0;
         ram_address_q <= '0;
         ram_wdata_q   <= '0;
      end else begin
         ram_enable_q <= write_now;
         if (write_now) begin
            ram_address_q <= address;
            ram_wdata_q   <= word_next;
         end
      end
   end

   // Status flags: done pulse and cnn_enable on leaving DRAIN, sticky overrun error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done       <= 1'b0;
         cnn_enable <= 1'b0;
         error      <= 1'b0;
      end else begin
         done <= drain_go;
         if (load_go) begin
            cnn_enable <= 1'b0;
            error      <= 1'b0;
         end
         if (drain_go) begin
            cnn_enable <= 1'b1;
            if (bus.in_valid) begin
               error <= 1'b1;
            end
         end
         if (write_now && last_word && (run_left != '0)) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_io_rle_stream_loader.sv
// Scoreboard bench for io_rle_stream_loader: expected RAM writes are queued
// from a bit-stream model when a job is issued; a monitor pops them as the
// DUT strobes the RAM port.
`timescale 1ns/1ps
module tb_io_rle_stream_loader;

   localparam int SECTION_W  = 16;
   localparam int LEN_W      = SECTION_W - 1;
   localparam int ROW_W      = 64;
   localparam int MEM_W      = 16;
   localparam int ADDR_W     = 16;
   localparam int ROWS_W     = 10;
   localparam int WPR        = ROW_W / MEM_W;
   localparam int WAIT_LIMIT = 2000;
   localparam logic [ADDR_W-1:0] IMG_BASE  = 16'h0000;
   localparam logic [ADDR_W-1:0] FILT_BASE = 16'h8000;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [MEM_W-1:0]  data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load = 1'b0;
   logic              cnn_img = 1'b0;
   logic              interrupt = 1'b0;
   logic [ROWS_W-1:0] num_rows = '0;
   logic              done;
   logic              cnn_enable;
   logic              error;

   io_rle_stream_loader_if #(.SECTION_W(SECTION_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

   io_rle_stream_loader #(
      .SECTION_W(SECTION_W), .ROW_W(ROW_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W),
      .ROWS_W(ROWS_W), .IMG_BASE(IMG_BASE), .FILT_BASE(FILT_BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .cnn_img(cnn_img),
      .num_rows(num_rows),
      .interrupt(interrupt),
      .bus(bus),
      .done(done),
      .cnn_enable(cnn_enable),
      .error(error)
   );

   wr_t              exp_q[$];
   wr_t              mon_exp;
   logic [SECTION_W-1:0] tok_q[$];
   int               gap_q[$];
   int               tests_run = 0;
   int               tests_failed = 0;
   int               done_count = 0;
   int               cycle = 0;
   int               last_wr_cycle = -10;

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter, read on the falling edge where it is stable.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic void push_write(input logic [ADDR_W-1:0] addr, input logic [MEM_W-1:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      exp_q.push_back(w);
   endfunction

   // Reference model: flatten all runs into one bit stream, cut it into
   // MEM_W-bit words MSB-first, keep the first rows*WPR words.
   function automatic void build_expected(input logic img, input int rows, output logic exp_err);
      logic bits[$];
      logic [MEM_W-1:0] data;
      int needed;
      foreach (tok_q[t]) begin
         for (int j = 0; j < int'(tok_q[t][LEN_W-1:0]); j++) bits.push_back(tok_q[t][SECTION_W-1]);
      end
      needed = rows * WPR * MEM_W;
      for (int w = 0; w < rows * WPR; w++) begin
         for (int b = 0; b < MEM_W; b++) data[MEM_W-1-b] = bits[w*MEM_W + b];
         push_write((img ? IMG_BASE : FILT_BASE) + ADDR_W'(w), data);
      end
      exp_err = (bits.size() > needed);
   endfunction

   // Monitor: every RAM strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (done) done_count++;
         if (bus.ram_enable) begin
            check_output("ram_write_with_enable", bus.ram_write, 1);
            last_wr_cycle = cycle;
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_write: got @%h=%h, expected no write", bus.ram_address, bus.ram_wdata);
            end else begin
               mon_exp = exp_q.pop_front();
               check_output("ram_address", bus.ram_address, mon_exp.addr);
               check_output("ram_wdata", bus.ram_wdata, mon_exp.data);
            end
         end else if (bus.ram_write) begin
            check_output("ram_write_without_enable", bus.ram_write, 0);
         end
      end
   end

   task automatic check_zero(input string name);
      check_output({name, "_in_ready"}, bus.in_ready, 0);
      check_output({name, "_ram_enable"}, bus.ram_enable, 0);
      check_output({name, "_ram_write"}, bus.ram_write, 0);
      check_output({name, "_ram_address"}, bus.ram_address, 0);
      check_output({name, "_ram_wdata"}, bus.ram_wdata, 0);
      check_output({name, "_done"}, done, 0);
      check_output({name, "_cnn_enable"}, cnn_enable, 0);
      check_output({name, "_error"}, error, 0);
   endtask

   task automatic start_load(input logic img, input logic [ROWS_W-1:0] rows);
      @(negedge clk);
      cnn_img  = img;
      num_rows = rows;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Present one token after an idle gap and hold it until the DUT takes it.
   task automatic send_token(input logic [SECTION_W-1:0] tok, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = tok;
      n = 0;
      while (!bus.in_ready && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL token_accept_timeout: got no in_ready for %h, expected acceptance", tok);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic exp_err, input bit chk_lat);
      int n;
      n = 0;
      while (done !== 1'b1 && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s_done_timeout: got no done in %0d cycles, expected a pulse", name, WAIT_LIMIT);
         return;
      end
      check_output({name, "_cnn_enable"}, cnn_enable, 1);
      check_output({name, "_error"}, error, exp_err);
      check_output({name, "_writes_pending"}, exp_q.size(), 0);
      if (chk_lat) check_output({name, "_done_after_write"}, cycle - last_wr_cycle, 1);
      @(negedge clk);
      check_output({name, "_done_width"}, done, 0);
      check_output({name, "_in_ready_idle"}, bus.in_ready, 0);
   endtask

   task automatic apply_stimulus(input string name, input logic img, input int rows);
      logic exp_err;
      build_expected(img, rows, exp_err);
      start_load(img, ROWS_W'(rows));
      foreach (tok_q[i]) send_token(tok_q[i], gap_q[i]);
      wait_done(name, exp_err, rows != 0);
   endtask

   task automatic run_random(input int count);
      logic img;
      int   rows;
      int   total;
      int   len;
      for (int t = 0; t < count; t++) begin
         img   = 1'($urandom_range(0, 1));
         rows  = $urandom_range(0, 3);
         total = 0;
         tok_q.delete();
         gap_q.delete();
         while (total < rows * WPR * MEM_W) begin
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            tok_q.push_back({1'($urandom_range(0, 1)), LEN_W'(len)});
            gap_q.push_back($urandom_range(0, 2));
            total += len;
         end
         apply_stimulus($sformatf("rand%0d", t), img, rows);
      end
   endtask

   task automatic wait_first_write(input string name);
      int n;
      n = 0;
      while (!bus.ram_enable && n < WAIT_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_first_write_seen"}, bus.ram_enable, 1);
   endtask

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios followed by randomized jobs.
   initial begin
      int dc;
      logic exp_err;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // Image mode, one row.
      tok_q = '{16'h8008, 16'h0008, 16'h8030};
      gap_q = '{0, 0, 0};
      apply_stimulus("t1_image", 1'b1, 1);

      // Filter mode, two rows, run spanning a row boundary.
      tok_q = '{16'h0046, 16'h803A};
      gap_q = '{0, 0};
      apply_stimulus("t2_filter", 1'b0, 2);

      // Overlong run, plus a token offered while finishing.
      tok_q = '{16'h8064};
      build_expected(1'b1, 1, exp_err);
      start_load(1'b1, 1);
      send_token(16'h8064, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0005;
      wait_done("t3_overrun", exp_err, 1);
      bus.in_valid = 1'b0;

      // Interrupt on the cycle the second word would be registered.
      start_load(1'b1, 1);
      check_output("t4_error_cleared", error, 0);
      check_output("t4_cnn_enable_cleared", cnn_enable, 0);
      push_write(IMG_BASE, 16'hFFFF);
      dc = done_count;
      send_token(16'h8040, 0);
      wait_first_write("t4");
      interrupt = 1'b1;
      @(negedge clk);
      interrupt = 1'b0;
      check_output("t4_write_suppressed", bus.ram_enable, 0);
      check_output("t4_in_ready_idle", bus.in_ready, 0);
      repeat (6) @(negedge clk);
      check_output("t4_no_done", done_count - dc, 0);
      check_output("t4_cnn_enable", cnn_enable, 0);
      check_output("t4_writes_pending", exp_q.size(), 0);

      // Backpressure gaps, zero-length tokens and a load while busy.
      tok_q = '{16'h8008, 16'h0000, 16'h0008, 16'h8000, 16'h8030};
      build_expected(1'b1, 1, exp_err);
      start_load(1'b1, 1);
      foreach (tok_q[i]) begin
         if (i == 2) begin
            cnn_img  = 1'b0;
            num_rows = 3;
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
         end
         send_token(tok_q[i], 3);
      end
      wait_done("t5_backpressure", exp_err, 1);

      // Asynchronous reset in the middle of a job, then an empty job.
      start_load(1'b1, 1);
      push_write(IMG_BASE, 16'hFFFF);
      send_token(16'h8040, 0);
      wait_first_write("t6");
      #2;
      rst = 1'b0;
      #1;
      check_zero("t6_async_reset");
      check_output("t6_writes_pending", exp_q.size(), 0);
      @(negedge clk);
      rst = 1'b1;
      tok_q.delete();
      gap_q.delete();
      apply_stimulus("t6_zero_rows", 1'b1, 0);

      run_random(10);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/io_rle_stream_loader.md
Name: io_rle_stream_loader

Overview:
Parametrised successor to the IO front end. It combines interface, decompressor and DMA into one streaming block with a valid/ready token input. It run-length-expands compressed sections into packed memory words and writes them to RAM at a mode-selected base address. It counts rows, aborts on interrupt, and signals done / cnn_enable to the CNN controller.

Parameters:
SECTION_W, 16, compressed token width; bit [SECTION_W-1] is the run value, bits [SECTION_W-2:0] are the run length.
ROW_W, 512, decompressed row width in bits; must be a multiple of MEM_W.
MEM_W, 16, RAM word width.
ADDR_W, 16, RAM address width.
ROWS_W, 10, width of the row-count input.
IMG_BASE, 0, first RAM address in image mode.
FILT_BASE, 16'h8000, first RAM address in filter mode.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
load  in  1  start pulse; sampled only in IDLE.
cnn_img  in  1  mode, latched at load: 1 = image (IMG_BASE), 0 = filter (FILT_BASE).
num_rows  in  ROWS_W  number of rows to produce, latched at load.
interrupt  in  1  synchronous abort.
in_valid  in  1  token valid.
in_data  in  SECTION_W  compressed token.
in_ready  out  1  token accept; a transfer occurs when in_valid & in_ready.
ram_enable  out  1  RAM access strobe.
ram_write  out  1  write strobe; always equal to ram_enable.
ram_address  out  ADDR_W  word address.
ram_wdata  out  MEM_W  packed word.
done  out  1  one-cycle completion pulse.
cnn_enable  out  1  level; high from done until the next accepted load.
error  out  1  sticky overrun flag; cleared on load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All outputs 0: in_ready, ram_enable, ram_write, ram_address, ram_wdata, done, cnn_enable, error.
  - Fill register, run counter and row counter cleared.
- States: IDLE, FETCH, EXPAND, DRAIN.
- IDLE:
  - On load=1: latch cnn_img and num_rows; address = base; clear error and cnn_enable.
  - If num_rows = 0: go to DRAIN. Otherwise go to FETCH.
  - load in any other state is ignored.
- FETCH:
  - in_ready = 1 (combinational from state).
  - On transfer: zero-length token is consumed with no effect, stay in FETCH. Otherwise latch value and length, go to EXPAND.
- EXPAND, each cycle:
  - k = min(run_remaining, MEM_W - fill). Append k copies of the value MSB-first: the first decompressed bit lands in ram_wdata[MEM_W-1].
  - When fill reaches MEM_W: registered write next cycle (ram_enable = ram_write = 1 for exactly one cycle, ram_address = current address); then address += 1 and fill = 0.
  - Row counter increments every ROW_W/MEM_W words.
  - Runs span row boundaries transparently.
  - Run exhausted with rows remaining: back to FETCH.
  - Final word of the final row written: go to DRAIN. Any leftover run bits are discarded and error is set.
- DRAIN:
  - in_ready = 1 and all tokens are discarded; error is set if any token arrives.
  - done pulses for one cycle on entry, cnn_enable rises with it, then return to IDLE.
  - In IDLE in_ready = 0, so later tokens stall.
- Interrupt (any non-IDLE state): next state IDLE. Any write that would be registered on that edge is suppressed. No done pulse; cnn_enable stays 0. Interrupt has priority over load, done and writes.
- Throughput: at most one word per cycle. A token longer than MEM_W produces back-to-back writes.
- Latency: accepted token to its first write is 2 cycles when the word completes in the first EXPAND cycle.
- Address wrap: the address wraps modulo 2^ADDR_W and is not flagged.

Test Plan:
(ROW_W=64, MEM_W=16 for the bench.)
1. Image mode, num_rows=1, tokens {1,8},{0,8},{1,48} -> writes @0:16'h FF00, @1..3:16'hFFFF; done pulse one cycle after last write; cnn_enable=1; error=0.
2. Filter mode, num_rows=2, tokens {0,70},{1,58} -> @8000..8003:0000, @8004:03FF, @8005..8007:FFFF; done; error=0.
3. num_rows=1, single token {1,100} -> four FFFF writes, error=1, done=1; extra token in DRAIN discarded.
4. Interrupt asserted on the cycle the 2nd word would be written -> no write registered at that edge, ram_enable=0, no done; next load restarts at IMG_BASE with error cleared.
5. Backpressure: in_valid gaps of 3 cycles, zero-length tokens, load pulsed while busy -> identical write sequence to test 1; the busy load has no effect.
6. rst=0 asynchronously mid-EXPAND -> all outputs 0 immediately, without waiting for a clock edge; num_rows=0 load afterwards -> done pulse, no writes.
